skew_feeder: RTL and testbench

- Consumer stage that drains ROWS parallel sync_fifo instances, one per systolic-array row, and presents one skewed row vector per beat to the array edge.
- Row i starts i beats after row 0; rows outside their active window are zero-filled.
- Each operation streams one tile of `len` vectors per row.
- Handles FIFO underflow and downstream backpressure by stalling, never by dropping data.

---
 rtl/skew_feeder.sv | 132 +++++++++++++
 tb/tb_skew_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - drains per-row FIFOs into a skewed row vector for a systolic array edge
module skew_feeder #(
    parameter int ROWS  = 4,
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    input  logic [ROWS-1:0]       fifo_empty,
    output logic [ROWS-1:0]       fifo_r_en,
    input  logic [ROWS*WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROWS*WIDTH-1:0] out_data,
    output logic [ROWS-1:0]       out_mask
);

    localparam int SW = LEN_W + $clog2(ROWS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [LEN_W-1:0] k_q, k_d;

    logic [SW-1:0]   k_ext;
    logic [SW-1:0]   last_step;
    logic [ROWS-1:0] act;
    logic [ROWS-1:0] blocked;
    logic            slot_free;
    logic            go;

    assign k_ext     = SW'(k_q);
    assign last_step = k_ext + SW'(ROWS - 2);

    // Row i owns steps [i, i+K); everything outside that window is zero-filled.
    always_comb begin
        act = '0;
        for (int i = 0; i < ROWS; i++) begin
            act[i] = (step_q >= SW'(i)) && (step_q < SW'(i) + k_ext);
        end
    end

    // A single empty active row stalls every row so the skew never slips.
    assign blocked   = act & fifo_empty;
    assign slot_free = !out_valid || out_ready;
    assign go        = (state_q == S_RUN) && (blocked == '0) && slot_free;
    assign fifo_r_en = go ? act : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        done    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_d = '0;
                    k_d    = len;
                    if (len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (go) begin
                    step_d = step_q + SW'(1);
                    if (step_q == last_step) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (slot_free) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mask is cleared with valid so an idle port presents all-zero data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_mask  <= '0;
        end else if (go) begin
            out_valid <= 1'b1;
            out_mask  <= act;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_mask  <= '0;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            out_data[i*WIDTH +: WIDTH] = out_mask[i] ? fifo_data[i*WIDTH +: WIDTH] : '0;
        end
    end

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - self-checking bench for skew_feeder against a per-beat skew model
module tb_skew_feeder;

    localparam int ROWS  = 4;
    localparam int WIDTH = 16;
    localparam int LEN_W = 8;
    localparam int NB    = ROWS * WIDTH;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [LEN_W-1:0]     len = '0;
    logic                 busy;
    logic                 done;
    logic [ROWS-1:0]      fifo_empty;
    logic [ROWS-1:0]      fifo_r_en;
    logic [NB-1:0]        fifo_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [NB-1:0]        out_data;
    logic [ROWS-1:0]      out_mask;

    always #5 clk = ~clk;

    skew_feeder #(.ROWS(ROWS), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mask   (out_mask)
    );

    // FIFO model: row i is loaded with 10i+1, 10i+2, ...; data_out moves only on a real read.
    int               load_gen = 0;
    int               seen_load = 0;
    int               load_n = 0;
    logic [WIDTH-1:0] mem [ROWS][16];
    int               rp  [ROWS] = '{default: 0};
    int               cnt [ROWS] = '{default: 0};
    logic [WIDTH-1:0] dout [ROWS] = '{default: '0};
    logic [ROWS-1:0]  hold = '0;

    always @(posedge clk) begin
        if (load_gen != seen_load) begin
            seen_load <= load_gen;
            for (int i = 0; i < ROWS; i++) begin
                rp[i]  <= 0;
                cnt[i] <= load_n;
                for (int j = 0; j < 16; j++) mem[i][j] <= WIDTH'(10 * i + 1 + j);
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (fifo_r_en[i] && !fifo_empty[i]) begin
                    dout[i] <= mem[i][rp[i]];
                    rp[i]   <= rp[i] + 1;
                    cnt[i]  <= cnt[i] - 1;
                end
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_data  = '0;
        for (int i = 0; i < ROWS; i++) begin
            fifo_empty[i] = (cnt[i] == 0) || hold[i];
            fifo_data[i*WIDTH +: WIDTH] = dout[i];
        end
    end

    function automatic logic [ROWS-1:0] act_of(input int s, input int kk);
        logic [ROWS-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) r[i] = (s >= i) && (s < i + kk);
        return r;
    endfunction

    function automatic logic [NB-1:0] data_of(input int b, input int kk);
        logic [NB-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (b >= i && b < i + kk) r[i*WIDTH +: WIDTH] = WIDTH'(10 * i + 1 + b - i);
        end
        return r;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    int tile_gen = 0;
    int exp_k = 0;
    int test_id = 0;

    int   seen_tile = 0;
    int   k = 0, cyc = 0, beat = 0, iss = 0;
    bit   tile = 1'b0;
    bit   rstn_d = 1'b1;
    bit   stall_p = 1'b0;
    logic [ROWS-1:0] mask_p;
    logic [NB-1:0]   data_p;
    logic [ROWS-1:0] got_mask [32];
    logic [NB-1:0]   got_data [32];

    logic [ROWS-1:0]  lit_base [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    logic [WIDTH-1:0] lit_row2 [3] = '{16'd21, 16'd22, 16'd23};
    logic [ROWS-1:0]  lit_one  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always @(negedge clk) begin
        if (!rstn_d) begin
            chk("reset_busy",      NB'(busy),      NB'(0));
            chk("reset_done",      NB'(done),      NB'(0));
            chk("reset_out_valid", NB'(out_valid), NB'(0));
            chk("reset_out_mask",  NB'(out_mask),  NB'(0));
            chk("reset_fifo_r_en", NB'(fifo_r_en), NB'(0));
            chk("reset_out_data",  out_data,       NB'(0));
            tile = 1'b0;
        end else begin
            if (tile_gen != seen_tile) begin
                seen_tile = tile_gen;
                tile = 1'b1;
                k    = exp_k;
                cyc  = 0;
                beat = 0;
                iss  = 0;
            end else if (tile) begin
                cyc++;
            end
            if (stall_p) begin
                chk("hold_valid", NB'(out_valid), NB'(1));
                chk("hold_mask",  NB'(out_mask),  NB'(mask_p));
                chk("hold_data",  out_data,       data_p);
            end
            if (out_valid && !out_ready) chk("stall_no_read", NB'(fifo_r_en), NB'(0));
            if (fifo_r_en != '0) begin
                chk("r_en_mask", NB'(fifo_r_en), NB'(act_of(iss, tile ? k : 0)));
                chk("r_en_not_empty", NB'(fifo_r_en & fifo_empty), NB'(0));
                iss++;
            end
            if (out_valid && out_ready) begin
                chk("beat_mask", NB'(out_mask), NB'(act_of(beat, tile ? k : 0)));
                chk("beat_data", out_data, data_of(beat, tile ? k : 0));
                if (beat < 32) begin
                    got_mask[beat] = out_mask;
                    got_data[beat] = out_data;
                end
                beat++;
            end
            if (tile && cyc >= 1) chk("busy", NB'(busy), NB'(k != 0 && !done));
            if (done) begin
                chk("done_in_tile", NB'(tile), NB'(1));
                chk("done_beats", NB'(beat), NB'((k == 0) ? 0 : k + ROWS - 1));
                if (k == 0) chk("done_latency", NB'(cyc), NB'(1));
                if (test_id == 1) begin
                    for (int j = 0; j < 6; j++) chk("lit_base_mask", NB'(got_mask[j]), NB'(lit_base[j]));
                    for (int j = 0; j < 3; j++)
                        chk("lit_row2_data", NB'(got_data[2+j][2*WIDTH +: WIDTH]), NB'(lit_row2[j]));
                end
                if (test_id == 6) begin
                    for (int j = 0; j < 4; j++) chk("lit_len1_mask", NB'(got_mask[j]), NB'(lit_one[j]));
                end
                tile = 1'b0;
            end
            if (tile && cyc > 150) begin
                chk("tile_timeout", NB'(1), NB'(0));
                tile = 1'b0;
            end
        end
        stall_p = out_valid && !out_ready;
        mask_p  = out_mask;
        data_p  = out_data;
        rstn_d  = rstn;
    end

    task automatic load_fifos(input int n);
        load_n = n;
        load_gen++;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int kk);
        start   = 1'b1;
        len     = LEN_W'(kk);
        exp_k   = kk;
        tile_gen++;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'hA5;
    endtask

    task automatic run_tile(input int kk, input bit rmode, input bit stall, input bit midstart);
        load_fifos((kk == 0) ? 3 : kk);
        hold = stall ? 4'b0010 : 4'b0000;
        pulse_start(kk);
        for (int n = 0; n < 300 && tile; n++) begin
            if (rmode) out_ready = (n % 4 == 0) || (n % 4 == 3);
            if (n == 4) hold = '0;
            if (midstart) start = (n == 2);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        hold      = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        test_id = 1; run_tile(3, 1'b0, 1'b0, 1'b0);
        test_id = 2; run_tile(3, 1'b0, 1'b1, 1'b0);
        test_id = 3; run_tile(3, 1'b1, 1'b0, 1'b0);
        test_id = 4; run_tile(0, 1'b0, 1'b0, 1'b0);
        test_id = 5; run_tile(3, 1'b0, 1'b0, 1'b1);
        test_id = 7; run_tile(5, 1'b1, 1'b1, 1'b0);

        test_id = 8;
        load_fifos(3);
        pulse_start(3);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        test_id = 6; run_tile(1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
